// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, operand select encodings and default widths.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned OP_W_DEF = 4;
  localparam int unsigned RA_W_DEF = 5;

  localparam logic [OP_W_DEF-1:0] OP_AND  = 4'd0;
  localparam logic [OP_W_DEF-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W_DEF-1:0] OP_XOR  = 4'd2;
  localparam logic [OP_W_DEF-1:0] OP_ADD  = 4'd3;
  localparam logic [OP_W_DEF-1:0] OP_SUB  = 4'd4;
  localparam logic [OP_W_DEF-1:0] OP_SLL  = 4'd5;
  localparam logic [OP_W_DEF-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_W_DEF-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_W_DEF-1:0] OP_SLT  = 4'd8;
  localparam logic [OP_W_DEF-1:0] OP_SLTU = 4'd9;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode/forward inputs and ALU-side outputs of the ID/EX operand stage.
interface alu_operand_stage_if #(
  parameter int unsigned XLEN = alu_pkg::XLEN_DEF,
  parameter int unsigned OP_W = alu_pkg::OP_W_DEF,
  parameter int unsigned RA_W = alu_pkg::RA_W_DEF
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [XLEN-1:0] in_pc;
  logic [RA_W-1:0] in_rs1_addr;
  logic [RA_W-1:0] in_rs2_addr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic            in_a_sel;
  logic            in_b_sel;
  logic            fwd_mem_valid;
  logic [RA_W-1:0] fwd_mem_rd;
  logic [XLEN-1:0] fwd_mem_data;
  logic            fwd_wb_valid;
  logic [RA_W-1:0] fwd_wb_rd;
  logic [XLEN-1:0] fwd_wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_op;
  logic [XLEN-1:0] out_A;
  logic [XLEN-1:0] out_B;
  logic [XLEN-1:0] out_rs2;

  modport master (
    output flush, in_valid, in_op, in_pc, in_rs1_addr, in_rs2_addr,
           in_rs1_data, in_rs2_data, in_imm, in_a_sel, in_b_sel,
           fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    input  in_ready, out_valid, out_op, out_A, out_B, out_rs2
  );

  modport slave (
    input  flush, in_valid, in_op, in_pc, in_rs1_addr, in_rs2_addr,
           in_rs1_data, in_rs2_data, in_imm, in_a_sel, in_b_sel,
           fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    output in_ready, out_valid, out_op, out_A, out_B, out_rs2
  );
endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Resolves one source operand: x0 forces zero, then EX/MEM, then MEM/WB, then register file.
module fwd_mux #(
  parameter int unsigned XLEN = alu_pkg::XLEN_DEF,
  parameter int unsigned RA_W = alu_pkg::RA_W_DEF
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            mem_valid,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data_c
);

  always_comb begin
    data_c = rf_data;
    if (addr == RA_W'(0)) begin
      data_c = XLEN'(0);
    end else if (mem_valid && (mem_rd == addr)) begin
      data_c = mem_data;
    end else if (wb_valid && (wb_rd == addr)) begin
      data_c = wb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: forwards sources, selects A/B, holds one entry under valid/ready.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned OP_W = OP_W_DEF,
  parameter int unsigned RA_W = RA_W_DEF
) (
  input logic                clk,
  input logic                rst,
  alu_operand_stage_if.slave bus
);

  logic [XLEN-1:0] rs1_fwd_c;
  logic [XLEN-1:0] rs2_fwd_c;
  logic [XLEN-1:0] a_nxt_c;
  logic [XLEN-1:0] b_nxt_c;
  logic            ready_c;
  logic            transfer_c;

  logic            valid_q;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] rs2_q;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .addr      (bus.in_rs1_addr),
    .rf_data   (bus.in_rs1_data),
    .mem_valid (bus.fwd_mem_valid),
    .mem_rd    (bus.fwd_mem_rd),
    .mem_data  (bus.fwd_mem_data),
    .wb_valid  (bus.fwd_wb_valid),
    .wb_rd     (bus.fwd_wb_rd),
    .wb_data   (bus.fwd_wb_data),
    .data_c    (rs1_fwd_c)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .addr      (bus.in_rs2_addr),
    .rf_data   (bus.in_rs2_data),
    .mem_valid (bus.fwd_mem_valid),
    .mem_rd    (bus.fwd_mem_rd),
    .mem_data  (bus.fwd_mem_data),
    .wb_valid  (bus.fwd_wb_valid),
    .wb_rd     (bus.fwd_wb_rd),
    .wb_data   (bus.fwd_wb_data),
    .data_c    (rs2_fwd_c)
  );

  // Flush blocks acceptance so the squashed instruction is never captured.
  always_comb begin
    ready_c    = 1'b0;
    transfer_c = 1'b0;
    a_nxt_c    = rs1_fwd_c;
    b_nxt_c    = rs2_fwd_c;
    ready_c    = !bus.flush && (!valid_q || bus.out_ready);
    transfer_c = bus.in_valid && ready_c;
    if (bus.in_a_sel == A_SEL_PC) begin
      a_nxt_c = bus.in_pc;
    end
    if (bus.in_b_sel == B_SEL_IMM) begin
      b_nxt_c = bus.in_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= OP_W'(0);
      a_q     <= XLEN'(0);
      b_q     <= XLEN'(0);
      rs2_q   <= XLEN'(0);
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (transfer_c) begin
      valid_q <= 1'b1;
      op_q    <= bus.in_op;
      a_q     <= a_nxt_c;
      b_q     <= b_nxt_c;
      rs2_q   <= rs2_fwd_c;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_op    = op_q;
  assign bus.out_A     = a_q;
  assign bus.out_B     = b_q;
  assign bus.out_rs2   = rs2_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU operation units (AND/OR/XOR/ADD/shift).
- Captures decoded operands, resolves data forwarding from the EX/MEM and MEM/WB stages, and selects the A/B sources.
- Presents registered A, B and op to the ALU under a valid/ready handshake, with stall and flush support.

Parameters:
XLEN, 32, datapath width of operands and forwarded data
OP_W, 4, width of ALU operation code
RA_W, 5, register address width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
flush  input  1  kill captured and incoming instruction (branch mispredict/trap)
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
in_op  input  OP_W  ALU operation code
in_pc  input  XLEN  instruction PC
in_rs1_addr  input  RA_W  source register 1 index
in_rs2_addr  input  RA_W  source register 2 index
in_rs1_data  input  XLEN  register-file read data 1
in_rs2_data  input  XLEN  register-file read data 2
in_imm  input  XLEN  sign-extended immediate
in_a_sel  input  1  0=rs1, 1=PC
in_b_sel  input  1  0=rs2, 1=immediate
fwd_mem_valid  input  1  EX/MEM holds a register-writing result
fwd_mem_rd  input  RA_W  EX/MEM destination index
fwd_mem_data  input  XLEN  EX/MEM result
fwd_wb_valid  input  1  MEM/WB holds a register-writing result
fwd_wb_rd  input  RA_W  MEM/WB destination index
fwd_wb_data  input  XLEN  MEM/WB result
out_valid  output  1  A/B/op valid to ALU
out_ready  input  1  ALU/EX consumes this cycle
out_op  output  OP_W  registered op code
out_A  output  XLEN  registered operand A
out_B  output  XLEN  registered operand B
out_rs2  output  XLEN  forwarded rs2 value (store data path)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. Reset: out_valid=0; out_op, out_A, out_B, out_rs2 = 0. in_ready is combinational and equals 1 out of reset.
- Handshake: in_ready = !out_valid || out_ready. A transfer occurs when in_valid && in_ready.
- Capture latency: 1 cycle. Captured values appear on out_* the cycle after transfer.
- Holding: out_* hold stable while out_valid && !out_ready (stall). No input is accepted during a stall.
- Output update:
  - Transfer: out_valid <= 1.
  - out_ready && no transfer: out_valid <= 0 (data regs may keep old values).
- Forwarding, combinational at capture, per source s in {rs1, rs2}:
  - Priority 1: if addr==0, use 0; x0 is never forwarded, and read data for x0 is forced to 0.
  - Priority 2: else if fwd_mem_valid && fwd_mem_rd==addr, use fwd_mem_data.
  - Priority 3: else if fwd_wb_valid && fwd_wb_rd==addr, use fwd_wb_data.
  - Otherwise use in_sN_data.
  - EX/MEM wins when both match.
- Operand select: A = in_a_sel ? in_pc : fwd_rs1. B = in_b_sel ? in_imm : fwd_rs2. out_rs2 = fwd_rs2 regardless of in_b_sel.
- Flush:
  - Next edge: out_valid <= 0.
  - in_ready is forced 0 that cycle and any incoming instruction is discarded.
  - Flush overrides transfer and stall. Data regs are don't-care.
- rst overrides flush and transfer.
- No arithmetic here; all widths are XLEN pass-through with no truncation or extension.
- Occupancy: one entry only; no skid buffer. A back-to-back stream is sustained at 1/cycle while out_ready=1.

Decomposition:
- Shared package alu_pkg:
  - ALU op code localparams (OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU).
  - Select encodings A_SEL_RS1/A_SEL_PC and B_SEL_RS2/B_SEL_IMM.
  - XLEN and RA_W defaults.
- Sub-module fwd_mux: one instance per source register. Purely combinational priority resolve of addr, rf data and the two forward ports.

Test Plan:
- Reset/basic: rst 1 cycle; then in_valid=1, op=OP_OR, rs1=x3 (data 0xF0F0_0000), rs2=x4 (data 0x0000_0F0F), b_sel=0, out_ready=1 -> next cycle out_valid=1, out_A=0xF0F0_0000, out_B=0x0000_0F0F, out_op=OP_OR.
- Forward priority: rs1=x5, fwd_mem (rd=5, 0x1111_1111) and fwd_wb (rd=5, 0x2222_2222) both valid -> out_A=0x1111_1111. With fwd_mem_valid=0 -> out_A=0x2222_2222.
- x0 guard: rs2=x0, in_rs2_data=0xDEAD_BEEF, fwd_mem rd=0 valid -> out_B=0, out_rs2=0.
- Select: a_sel=1, pc=0x0000_1000; b_sel=1, imm=0xFFFF_FFFC -> out_A=0x0000_1000, out_B=0xFFFF_FFFC, out_rs2 = forwarded rs2.
- Stall: out_valid=1, out_ready=0 for 3 cycles while in_valid=1 with new data -> in_ready=0, out_* unchanged. Release out_ready -> new instruction appears 1 cycle later, no loss or duplication.
- Flush: flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the incoming instruction is never presented. rst asserted mid-stall -> out_valid=0, out_A=out_B=0.
